cmd_dispatch_scheduler: RTL and testbench

Buffered two-core command scheduler between the host command stream and Core0/Core1.
- Per-core FIFOs hold accepted commands, so a busy core no longer blocks commands for the idle core (no head-of-line blocking).
- Sequences start pulses to each core against its ready signal.
- Treats HALT as a global barrier: drain all queues, wait for both cores idle, then halt.

---
 rtl/cmd_dispatch_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_cmd_dispatch_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_dispatch_scheduler.sv
// Two-core command scheduler: per-core FIFOs, start/ready sequencing, HALT as a drain barrier.
// Optional DISPATCH_PERF_EN adds issue/stall performance counters.
module cmd_dispatch_scheduler #(
  parameter int DEPTH = 4,
  parameter int CMD_W = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  input  logic [CMD_W-1:0]         cmd_data,
  output logic                     cmd_ready,
  output logic                     core0_start,
  output logic [CMD_W-1:0]         core0_cmd,
  input  logic                     core0_ready,
  output logic                     core1_start,
  output logic [CMD_W-1:0]         core1_cmd,
  input  logic                     core1_ready,
  output logic [$clog2(DEPTH):0]   q0_level,
  output logic [$clog2(DEPTH):0]   q1_level,
  output logic                     busy,
  output logic                     halted
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0]              issue_cnt0,
  output logic [31:0]              issue_cnt1,
  output logic [31:0]              stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [7:0] OP_HALT = 8'h00;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [CMD_W-1:0] mem_r    [2][DEPTH];
  logic [AW-1:0]    wr_ptr_r [2];
  logic [AW-1:0]    rd_ptr_r [2];
  logic [LW-1:0]    level_r  [2];
  logic [CMD_W-1:0] cmd_r    [2];
  logic [1:0]       start_r;
  logic             halted_r;

  logic [1:0]       ready_s;
  logic [1:0]       full_s;
  logic [1:0]       empty_s;
  logic [1:0]       enq_s;
  logic [1:0]       issue_s;
  logic             is_halt_s;
  logic             tgt_s;
  logic             cmd_ready_s;
  logic             halt_acc_s;
  logic             drain_done_s;

  assign ready_s   = {core1_ready, core0_ready};
  assign is_halt_s = (cmd_data[CMD_W-1 -: 8] == OP_HALT);
  assign tgt_s     = cmd_data[48];

  // Queue occupancy flags
  always_comb begin
    full_s  = 2'b00;
    empty_s = 2'b00;
    for (int c = 0; c < 2; c++) begin
      full_s[c]  = (level_r[c] == LW'(DEPTH));
      empty_s[c] = (level_r[c] == '0);
    end
  end

  // Accept decision; a full queue refuses even if it is popping this cycle
  always_comb begin
    cmd_ready_s = 1'b0;
    if (!rst_n) begin
      cmd_ready_s = 1'b0;
    end else if (state_r == ST_RUN) begin
      if (is_halt_s) begin
        cmd_ready_s = 1'b1;
      end else begin
        cmd_ready_s = !full_s[tgt_s];
      end
    end else begin
      cmd_ready_s = 1'b0;
    end
  end

  assign halt_acc_s = cmd_valid && cmd_ready_s && is_halt_s;
  assign enq_s[0]   = cmd_valid && cmd_ready_s && !is_halt_s && !tgt_s;
  assign enq_s[1]   = cmd_valid && cmd_ready_s && !is_halt_s && tgt_s;
  // The !start_r term covers the cycle before the core drops its ready
  assign issue_s[0] = !empty_s[0] && ready_s[0] && !start_r[0] && (state_r != ST_HALTED);
  assign issue_s[1] = !empty_s[1] && ready_s[1] && !start_r[1] && (state_r != ST_HALTED);

  assign drain_done_s = empty_s[0] && empty_s[1] && (&ready_s) && (start_r == 2'b00);

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (halt_acc_s) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_done_s) begin
          state_next_s = ST_HALTED;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_HALTED: state_next_s = ST_HALTED;
      default:   state_next_s = ST_RUN;
    endcase
  end

  // State and sticky halt registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_RUN;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      halted_r <= (state_next_s == ST_HALTED);
    end
  end

  // Queue pointers, levels, and core start/command registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_r <= 2'b00;
      for (int c = 0; c < 2; c++) begin
        wr_ptr_r[c] <= '0;
        rd_ptr_r[c] <= '0;
        level_r[c]  <= '0;
        cmd_r[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        start_r[c] <= issue_s[c];
        if (enq_s[c]) begin
          wr_ptr_r[c] <= wr_ptr_r[c] + AW'(1'b1);
        end
        if (issue_s[c]) begin
          rd_ptr_r[c] <= rd_ptr_r[c] + AW'(1'b1);
          cmd_r[c]    <= mem_r[c][rd_ptr_r[c]];
        end
        case ({enq_s[c], issue_s[c]})
          2'b10:   level_r[c] <= level_r[c] + LW'(1'b1);
          2'b01:   level_r[c] <= level_r[c] - LW'(1'b1);
          default: level_r[c] <= level_r[c];
        endcase
      end
    end
  end

  // Queue storage; contents are don't-care once pointers reset
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (enq_s[c]) begin
        mem_r[c][wr_ptr_r[c]] <= cmd_data;
      end
    end
  end

  assign cmd_ready   = cmd_ready_s;
  assign core0_start = start_r[0];
  assign core1_start = start_r[1];
  assign core0_cmd   = cmd_r[0];
  assign core1_cmd   = cmd_r[1];
  assign q0_level    = level_r[0];
  assign q1_level    = level_r[1];
  assign halted      = halted_r;
  assign busy        = !empty_s[0] || !empty_s[1] || !core0_ready || !core1_ready;

`ifdef DISPATCH_PERF_EN
  logic [31:0] issue_cnt0_r;
  logic [31:0] issue_cnt1_r;
  logic [31:0] stall_cnt_r;

  // Performance counters, frozen once halted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt0_r <= 32'd0;
      issue_cnt1_r <= 32'd0;
      stall_cnt_r  <= 32'd0;
    end else if (state_r != ST_HALTED) begin
      if (issue_s[0]) begin
        issue_cnt0_r <= issue_cnt0_r + 32'd1;
      end
      if (issue_s[1]) begin
        issue_cnt1_r <= issue_cnt1_r + 32'd1;
      end
      if (cmd_valid && !cmd_ready_s && (state_r == ST_RUN)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
    end
  end

  assign issue_cnt0 = issue_cnt0_r;
  assign issue_cnt1 = issue_cnt1_r;
  assign stall_cnt  = stall_cnt_r;
`endif

endmodule

// File: tb/tb_cmd_dispatch_scheduler.sv
// Scoreboard bench for cmd_dispatch_scheduler: expected core commands are queued at
// stimulus time and checked by a monitor whenever a start pulse appears.
module tb_cmd_dispatch_scheduler;
  localparam int DEPTH = 4;
  localparam int CMD_W = 64;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic [CMD_W-1:0] cmd_data;
  logic             cmd_ready;
  logic             core0_start, core1_start;
  logic [CMD_W-1:0] core0_cmd, core1_cmd;
  logic             core0_ready, core1_ready;
  logic [LW-1:0]    q0_level, q1_level;
  logic             busy, halted;
`ifdef DISPATCH_PERF_EN
  logic [31:0]      issue_cnt0, issue_cnt1, stall_cnt;
  logic [31:0]      snap_issue0, snap_stall;
`endif

  cmd_dispatch_scheduler #(.DEPTH(DEPTH), .CMD_W(CMD_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .core0_start(core0_start), .core0_cmd(core0_cmd),
    .core0_ready(core0_ready), .core1_start(core1_start), .core1_cmd(core1_cmd),
    .core1_ready(core1_ready), .q0_level(q0_level), .q1_level(q1_level),
    .busy(busy), .halted(halted)
`ifdef DISPATCH_PERF_EN
    , .issue_cnt0(issue_cnt0), .issue_cnt1(issue_cnt1), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp0_q[$];
  logic [63:0] exp1_q[$];
  logic prev0 = 1'b0;
  logic prev1 = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [7:0] op, input logic core, input logic [47:0] pay);
    return {op, 7'd0, core, pay};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the command until accepted (bounded); returns one ns after the transfer edge
  task automatic send(input logic [63:0] c, output int waited);
    waited    = 0;
    cmd_valid = 1'b1;
    cmd_data  = c;
    #1;
    while (!cmd_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!cmd_ready) chk("send_timeout", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Monitor: every start pulse must match the oldest expected command for that core
  always @(negedge clk) begin
    if (!rst_n) begin
      prev0 = 1'b0;
      prev1 = 1'b0;
    end else begin
      if (core0_start) begin
        chk("c0_holdoff", 64'(prev0), 64'd0);
        chk("c0_start_expected", 64'(exp0_q.size() > 0), 64'd1);
        if (exp0_q.size() > 0) chk("c0_cmd_order", core0_cmd, exp0_q.pop_front());
      end
      if (core1_start) begin
        chk("c1_holdoff", 64'(prev1), 64'd0);
        chk("c1_start_expected", 64'(exp1_q.size() > 0), 64'd1);
        if (exp1_q.size() > 0) chk("c1_cmd_order", core1_cmd, exp1_q.pop_front());
      end
      prev0 = core0_start;
      prev1 = core1_start;
    end
  end

  initial begin
    int w;
    int cyc;
    logic [63:0] a, b, d, c1, c2, c3, e;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = '0;
    core0_ready = 1'b0; core1_ready = 1'b0;
    #2;
    chk("rst_busy_cores_not_ready", 64'(busy), 64'd1);
    cmd_valid = 1'b1; cmd_data = mk(8'h10, 1'b0, 48'h1);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_q0_level", 64'(q0_level), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_core0_start", 64'(core0_start), 64'd0);
    chk("rst_core0_cmd", core0_cmd, 64'd0);
    cmd_data = mk(8'h00, 1'b0, 48'h0);
    #1;
    chk("rst_halt_not_ready", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b0; core0_ready = 1'b1; core1_ready = 1'b1;
    #1;
    chk("rst_busy_cores_ready", 64'(busy), 64'd0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    tick();

    // 1: cross-core no-blocking
    core0_ready = 1'b0; core1_ready = 1'b1;
    a = mk(8'h11, 1'b0, 48'hA);
    b = mk(8'h12, 1'b1, 48'hB);
    exp0_q.push_back(a); send(a, w); chk("t1_a_wait", 64'(w), 64'd0);
    exp1_q.push_back(b); send(b, w); chk("t1_b_wait", 64'(w), 64'd0);
    chk("t1_no_bypass", 64'(core1_start), 64'd0);
    chk("t1_q1_level", 64'(q1_level), 64'd1);
    tick();
    chk("t1_core1_start", 64'(core1_start), 64'd1);
    chk("t1_core1_cmd", core1_cmd, b);
    chk("t1_q0_level", 64'(q0_level), 64'd1);
    chk("t1_core0_idle", 64'(core0_start), 64'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    core0_ready = 1'b1;
    tick();
    chk("t1_a_issued", 64'(core0_start), 64'd1);
    chk("t1_q0_empty", 64'(q0_level), 64'd0);
    core0_ready = 1'b0;
    tick();

    // 2: full queue
`ifdef DISPATCH_PERF_EN
    snap_issue0 = issue_cnt0;
    snap_stall  = stall_cnt;
`endif
    for (int i = 0; i < 5; i++) exp0_q.push_back(mk(8'h20 + 8'(i), 1'b0, 48'(i)));
    for (int i = 0; i < 4; i++) begin
      d = exp0_q[i];
      send(d, w);
      chk("t2_accept_wait", 64'(w), 64'd0);
    end
    chk("t2_q0_full", 64'(q0_level), 64'd4);
    cmd_valid = 1'b1; cmd_data = exp0_q[4];
    #1;
    chk("t2_fifth_refused", 64'(cmd_ready), 64'd0);
    repeat (3) tick();
    chk("t2_still_refused", 64'(cmd_ready), 64'd0);
    core0_ready = 1'b1;
    #1;
    chk("t2_full_while_popping", 64'(cmd_ready), 64'd0);
    tick();
    chk("t2_level_after_pop", 64'(q0_level), 64'd3);
    chk("t2_ready_after_pop", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
    chk("t2_fifth_accepted", 64'(q0_level), 64'd4);
    repeat (10) tick();
    chk("t2_drained", 64'(q0_level), 64'd0);
`ifdef DISPATCH_PERF_EN
    chk("perf_stall_cnt", 64'(stall_cnt - snap_stall), 64'd4);
    chk("perf_issue_cnt0", 64'(issue_cnt0 - snap_issue0), 64'd5);
`endif
    core0_ready = 1'b0;

    // 3: holdoff and order on core1
    core1_ready = 1'b1;
    c1 = mk(8'h31, 1'b1, 48'hC1);
    c2 = mk(8'h32, 1'b1, 48'hC2);
    c3 = mk(8'h33, 1'b1, 48'hC3);
    exp1_q.push_back(c1); exp1_q.push_back(c2); exp1_q.push_back(c3);
    send(c1, w); send(c2, w); send(c3, w);
    chk("t3_c3_wait", 64'(w), 64'd0);
    chk("t3_q1_level", 64'(q1_level), 64'd2);
    chk("t3_holdoff_gap", 64'(core1_start), 64'd0);
    tick();
    chk("t3_c2_start", 64'(core1_start), 64'd1);
    chk("t3_c2_cmd", core1_cmd, c2);
    tick();
    chk("t3_gap2", 64'(core1_start), 64'd0);
    tick();
    chk("t3_c3_start", 64'(core1_start), 64'd1);
    chk("t3_c3_cmd", core1_cmd, c3);
    chk("t3_q1_empty", 64'(q1_level), 64'd0);
    tick();

    // 4: HALT barrier
    core0_ready = 1'b0;
    exp0_q.push_back(mk(8'h41, 1'b0, 48'h41)); exp0_q.push_back(mk(8'h42, 1'b0, 48'h42));
    d = exp0_q[0]; send(d, w);
    d = exp0_q[1]; send(d, w);
    chk("t4_q0_level", 64'(q0_level), 64'd2);
    core0_ready = 1'b1;
    send(mk(8'h00, 1'b0, 48'h0), w);
    chk("t4_halt_wait", 64'(w), 64'd0);
    chk("t4_not_halted_yet", 64'(halted), 64'd0);
    cmd_valid = 1'b1; cmd_data = mk(8'h43, 1'b1, 48'h43);
    #1;
    chk("t4_drain_refuses", 64'(cmd_ready), 64'd0);
    cyc = 0;
    while (!halted && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("t4_halted", 64'(halted), 64'd1);
    chk("t4_drain_cycles", 64'(cyc), 64'd4);
    chk("t4_q0_empty_at_halt", 64'(q0_level), 64'd0);
    chk("t4_all_issued", 64'(exp0_q.size()), 64'd0);
    repeat (3) tick();
    chk("t4_halted_refuses", 64'(cmd_ready), 64'd0);
    chk("t4_q1_untouched", 64'(q1_level), 64'd0);
    chk("t4_halted_sticky", 64'(halted), 64'd1);
    cmd_valid = 1'b0;

    // 5: async reset mid-operation
    #2; rst_n = 1'b0;
    @(posedge clk); #3; rst_n = 1'b1;
    tick();
    core0_ready = 1'b0;
    send(mk(8'h51, 1'b0, 48'h1), w);
    send(mk(8'h52, 1'b0, 48'h2), w);
    send(mk(8'h53, 1'b0, 48'h3), w);
    send(mk(8'h00, 1'b0, 48'h0), w);
    chk("t5_q0_level_drain", 64'(q0_level), 64'd3);
    cmd_valid = 1'b1; cmd_data = mk(8'h54, 1'b1, 48'h4);
    #2; rst_n = 1'b0;
    #1;
    chk("t5_q0_cleared", 64'(q0_level), 64'd0);
    chk("t5_halted_clear", 64'(halted), 64'd0);
    chk("t5_core0_start", 64'(core0_start), 64'd0);
    chk("t5_core1_start", 64'(core1_start), 64'd0);
    chk("t5_cmd_ready", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b0;
    @(posedge clk); #3; rst_n = 1'b1;
    tick();
    core0_ready = 1'b1;
    e = mk(8'h55, 1'b0, 48'h55);
    exp0_q.push_back(e);
    send(e, w);
    chk("t5_new_accept_wait", 64'(w), 64'd0);
    chk("t5_new_no_bypass", 64'(core0_start), 64'd0);
    tick();
    chk("t5_new_start", 64'(core0_start), 64'd1);
    chk("t5_new_cmd", core0_cmd, e);
    tick(); tick();

    // HALT into an idle, empty scheduler: one DRAIN cycle then halted
    send(mk(8'h00, 1'b1, 48'h0), w);
    chk("t6_halt_drain_cycle", 64'(halted), 64'd0);
    tick();
    chk("t6_halt_quick", 64'(halted), 64'd1);

    tick();
    chk("end_exp0_empty", 64'(exp0_q.size()), 64'd0);
    chk("end_exp1_empty", 64'(exp1_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
